dram_pattern_tester: RTL

//  Parametrised SDRAM self-test sequencer; sits between the sdram controller
//  (enable/busy/rd_ready handshake) and board LEDs/debug. Writes a selectable

---
 rtl/dram_tester_pkg.sv | 25 ++
 rtl/dram_pattern_tester_if.sv | 26 ++
 rtl/checksum16.sv | 28 ++
 rtl/dram_pattern_gen.sv | 34 +++
 rtl/dram_pattern_tester.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dram_tester_pkg.sv
// SDRAM pattern tester shared types: FSM state encoding and pattern mode codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_tester_pkg;

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_WR,
      S_WR_WAIT,
      S_WR_INC,
      S_RD,
      S_RD_WAIT,
      S_VAL,
      S_RD_INC,
      S_NEXT_PASS,
      S_DONE
   } state_t;

   localparam logic [1:0] MODE_CSUM  = 2'd0;  // checksum of the address
   localparam logic [1:0] MODE_ADDR  = 2'd1;  // address as data
   localparam logic [1:0] MODE_NADDR = 2'd2;  // inverted address
   localparam logic [1:0] MODE_WALK  = 2'd3;  // walking one

endpackage

// File: rtl/dram_pattern_tester_if.sv
// Tester <-> SDRAM controller command/data bundle.
// Latency: n/a (wires only).
// Backpressure: controller holds busy_i while a command is in flight; rd_ready_i marks read data.
// Ports: master = tester side (drives addr/data/enables), slave = controller side.
interface dram_pattern_tester_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16
);
   logic                  busy_i;
   logic                  rd_ready_i;
   logic [DATA_WIDTH-1:0] rd_data_i;
   logic [DATA_WIDTH-1:0] wr_data_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic                  wr_enable_o;
   logic                  rd_enable_o;

   modport master (
      input  busy_i, rd_ready_i, rd_data_i,
      output wr_data_o, addr_o, wr_enable_o, rd_enable_o
   );

   modport slave (
      output busy_i, rd_ready_i, rd_data_i,
      input  wr_data_o, addr_o, wr_enable_o, rd_enable_o
   );
endinterface

// File: rtl/checksum16.sv
// 16-bit ones-complement (internet style) checksum of a zero-padded word vector.
// Latency: combinational.
// Backpressure: none.
// Ports: data (IN_WIDTH) in, csum (16) out.
module checksum16 #(
   parameter int IN_WIDTH = 24
) (
   input  logic [IN_WIDTH-1:0] data,
   output logic [15:0]         csum
);
   localparam int NW = (IN_WIDTH + 15) / 16;
   localparam int PW = NW * 16;

   logic [PW-1:0] padded;
   logic [31:0]   acc;
   logic [16:0]   fold;

   always_comb begin
      padded = PW'(data);
      acc    = '0;
      for (int i = 0; i < NW; i++) begin
         acc = acc + 32'(padded[i*16 +: 16]);
      end
      // Two folds are enough: the first leaves at most one carry bit.
      fold = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
      csum = ~(fold[15:0] + {15'b0, fold[16]});
   end
endmodule

// File: rtl/dram_pattern_gen.sv
// Test pattern generator: address + mode + invert -> data word.
// Latency: combinational.
// Backpressure: none.
// Ports: addr, mode, invert in; data out.
module dram_pattern_gen
   import dram_tester_pkg::*;
#(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            mode,
   input  logic                  invert,
   output logic [DATA_WIDTH-1:0] data
);
   logic [15:0]           csum;
   logic [DATA_WIDTH-1:0] base;

   checksum16 #(.IN_WIDTH(ADDR_WIDTH)) u_csum (
      .data (addr),
      .csum (csum)
   );

   always_comb begin
      base = '0;
      unique case (mode)
         MODE_CSUM:  base = {(DATA_WIDTH/16){csum}};
         MODE_ADDR:  base = DATA_WIDTH'(addr);
         MODE_NADDR: base = ~DATA_WIDTH'(addr);
         default:    base = DATA_WIDTH'(1) << (addr % DATA_WIDTH);
      endcase
      data = base ^ {DATA_WIDTH{invert}};
   end
endmodule

// File: rtl/dram_pattern_tester.sv
// SDRAM self-test sequencer: write pattern to every address, read back, compare, N passes.
// Latency: write 3 cycles + controller time per word; read adds 1 compare cycle.
// Backpressure: holds enable until controller busy_i; waits busy_i low / rd_ready_i to advance.
// Ports: clk, rst_n, start_i/mode_i/passes_i/stop_on_fail_i control, mem (controller bus),
//        done_o/pass_o/fail_o/err_count_o/first_fail_* status, leds_o progress/status.
module dram_pattern_tester
   import dram_tester_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 24,
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LAST   = '1,
   parameter int                    INIT_CYCLES = 64,
   parameter int                    ERR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic [7:0]            passes_i,
   input  logic                  stop_on_fail_i,
   dram_pattern_tester_if.master mem,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  fail_o,
   output logic [ERR_WIDTH-1:0]  err_count_o,
   output logic [ADDR_WIDTH-1:0] first_fail_addr_o,
   output logic [DATA_WIDTH-1:0] first_fail_data_o,
   output logic [7:0]            leds_o
);
   localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int LW = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

   state_t                state_q, state_d;
   logic [CW-1:0]         init_cnt_q;
   logic [1:0]            mode_q;
   logic [7:0]            passes_q, pass_idx_q;
   logic                  stop_q;
   logic [ADDR_WIDTH-1:0] addr_q, ff_addr_q;
   logic [DATA_WIDTH-1:0] ff_data_q, rd_cap_q, pat;
   logic [ERR_WIDTH-1:0]  err_q;
   logic                  done_q, pass_q, fail_q;
   logic                  wr_en, rd_en, last_addr, miscmp, any_err, running;
   logic [LW-1:0]         addr_ext;

   // One generator serves both the write data and the read-back expectation.
   dram_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_gen (
      .addr   (addr_q),
      .mode   (mode_q),
      .invert (pass_idx_q[0]),
      .data   (pat)
   );

   assign last_addr = (addr_q == ADDR_LAST);
   assign miscmp    = (rd_cap_q != pat);
   // Error state as it will be after this cycle, so the final verdict sees a VAL-cycle miss.
   assign any_err   = (err_q != '0) || ((state_q == S_VAL) && miscmp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         S_INIT:      if (init_cnt_q == '0) state_d = S_IDLE;
         S_IDLE:      if (start_i) state_d = S_WR;
         S_WR: begin
            wr_en = 1'b1;
            if (mem.busy_i) state_d = S_WR_WAIT;
         end
         S_WR_WAIT:   if (!mem.busy_i) state_d = S_WR_INC;
         S_WR_INC:    state_d = last_addr ? S_RD : S_WR;
         S_RD: begin
            rd_en = 1'b1;
            // Fast controllers may answer in the accept cycle; skip the wait state then.
            if (mem.rd_ready_i)  state_d = S_VAL;
            else if (mem.busy_i) state_d = S_RD_WAIT;
         end
         S_RD_WAIT:   if (mem.rd_ready_i) state_d = S_VAL;
         S_VAL:       state_d = (miscmp && stop_q) ? S_DONE : S_RD_INC;
         S_RD_INC:    state_d = last_addr ? S_NEXT_PASS : S_RD;
         S_NEXT_PASS: state_d = ((passes_q != 8'd0) && ((pass_idx_q + 8'd1) == passes_q))
                                ? S_DONE : S_WR;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt_q <= CW'(INIT_CYCLES - 1);
         mode_q     <= '0;
         passes_q   <= '0;
         stop_q     <= 1'b0;
         addr_q     <= '0;
         pass_idx_q <= '0;
         err_q      <= '0;
         ff_addr_q  <= '0;
         ff_data_q  <= '0;
         rd_cap_q   <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         if ((state_q == S_INIT) && (init_cnt_q != '0)) init_cnt_q <= init_cnt_q - CW'(1);
         case (state_q)
            S_IDLE: if (start_i) begin
               mode_q     <= mode_i;
               passes_q   <= passes_i;
               stop_q     <= stop_on_fail_i;
               addr_q     <= '0;
               pass_idx_q <= '0;
               err_q      <= '0;
               ff_addr_q  <= '0;
               ff_data_q  <= '0;
               done_q     <= 1'b0;
               pass_q     <= 1'b0;
               fail_q     <= 1'b0;
            end
            S_WR_INC, S_RD_INC: addr_q <= last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
            S_RD, S_RD_WAIT: if (mem.rd_ready_i) rd_cap_q <= mem.rd_data_i;
            S_VAL: if (miscmp) begin
               if (err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
               if (err_q == '0) begin
                  ff_addr_q <= addr_q;
                  ff_data_q <= rd_cap_q;
               end
            end
            S_NEXT_PASS: pass_idx_q <= pass_idx_q + 8'd1;
            default: ;
         endcase
         if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_q <= 1'b1;
            pass_q <= !any_err;
            fail_q <= any_err;
         end
      end
   end

   always_comb begin
      addr_ext = LW'(addr_q) << (LW - ADDR_WIDTH);
      running  = !(state_q inside {S_INIT, S_IDLE, S_DONE});
      leds_o   = running ? addr_ext[LW-1 -: 8] : {pass_q, fail_q, (err_q != '0), 5'b0};
   end

   assign mem.addr_o        = addr_q;
   assign mem.wr_enable_o   = wr_en;
   assign mem.rd_enable_o   = rd_en;
   assign mem.wr_data_o     = wr_en ? pat : '0;
   assign done_o            = done_q;
   assign pass_o            = pass_q;
   assign fail_o            = fail_q;
   assign err_count_o       = err_q;
   assign first_fail_addr_o = ff_addr_q;
   assign first_fail_data_o = ff_data_q;
endmodule
